// File: rtl/ser_arbiter.sv
// Round-robin arbiter sharing one serializer between N requesters.
// Latency: grant in the IDLE cycle; load strobe one cycle later; done_o one cycle after busy drops.
// Backpressure: req_ready_o is only offered in IDLE with the serializer idle; requesters hold until ready.
//
// Ports:
//   clk_i, arstn_i        clock, asynchronous active-low reset
//   req_data_i/mod_i/val_i  per-requester 16-bit word, 4-bit bit count, valid
//   req_ready_o            one-hot accept (combinational)
//   ser_data_o/mod_o/val_o  word, bit count and single-cycle load strobe to the serializer
//   ser_busy_i             serializer busy
//   grant_id_o             current or last owner
//   active_o               transaction in flight
//   done_o                 one-cycle pulse when the serializer finishes
//   drop_cnt_o             saturating count of rejected (bit count < 3) requests
//   err_o                  sticky: serializer never went busy after a load
module ser_arbiter #(
  parameter int N     = 4,
  parameter int CNT_W = 8,
  localparam int IW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk_i,
  input  logic             arstn_i,
  input  logic [16*N-1:0]  req_data_i,
  input  logic [4*N-1:0]   req_mod_i,
  input  logic [N-1:0]     req_val_i,
  output logic [N-1:0]     req_ready_o,
  output logic [15:0]      ser_data_o,
  output logic [3:0]       ser_data_mod_o,
  output logic             ser_data_val_o,
  input  logic             ser_busy_i,
  output logic [IW-1:0]    grant_id_o,
  output logic             active_o,
  output logic             done_o,
  output logic [CNT_W-1:0] drop_cnt_o,
  output logic             err_o
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    r_gid;
  logic [15:0]      r_data;
  logic [3:0]       r_mod;
  logic             r_val;
  logic             r_done;
  logic [CNT_W-1:0] r_drop;
  logic             r_err;

  logic             w_any;
  logic [IW-1:0]    w_win;
  logic             w_xfer;
  logic [15:0]      w_sel_data;
  logic [3:0]       w_sel_mod;

  // Search starts one past the last owner and wraps, so the last owner
  // is considered last. With N=1 the modulo collapses to index 0.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int i = 1; i <= N; i++) begin
      if (!w_any && req_val_i[(int'(r_ptr) + i) % N]) begin
        w_any = 1'b1;
        w_win = IW'((int'(r_ptr) + i) % N);
      end
    end
  end

  assign w_xfer     = (r_state == S_IDLE) && !ser_busy_i && w_any;
  assign w_sel_data = req_data_i[16*int'(w_win) +: 16];
  assign w_sel_mod  = req_mod_i[4*int'(w_win) +: 4];

  always_comb begin
    req_ready_o = '0;
    for (int k = 0; k < N; k++) begin
      req_ready_o[k] = w_xfer && (w_win == IW'(k));
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_gid   <= '0;
      r_data  <= '0;
      r_mod   <= '0;
      r_val   <= 1'b0;
      r_done  <= 1'b0;
      r_drop  <= '0;
      r_err   <= 1'b0;
    end else begin
      // Strobe and done are single-cycle pulses; they are re-armed only below.
      r_val  <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_ptr  <= w_win;
            r_gid  <= w_win;
            r_data <= w_sel_data;
            r_mod  <= w_sel_mod;
            if (w_sel_mod >= 4'd3) begin
              r_val   <= 1'b1;
              r_state <= S_ISSUE;
            end else if (r_drop != {CNT_W{1'b1}}) begin
              // Short words are consumed but never loaded; stay IDLE so
              // the next grant can happen on the following cycle.
              r_drop <= r_drop + CNT_W'(1);
            end
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (ser_busy_i) begin
            r_state <= S_WAIT_DONE;
          end else begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_WAIT_DONE: begin
          if (!ser_busy_i) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ser_data_o     = r_data;
  assign ser_data_mod_o = r_mod;
  assign ser_data_val_o = r_val;
  assign grant_id_o     = r_gid;
  assign active_o       = (r_state != S_IDLE);
  assign done_o         = r_done;
  assign drop_cnt_o     = r_drop;
  assign err_o          = r_err;

endmodule

// File: doc/ser_arbiter.md
Name: ser_arbiter

Overview:
Round-robin arbiter that shares one serializer between N parallel-word requesters. Each requester offers a 16-bit word and a bit-count over a valid/ready handshake. The block grants one requester at a time, issues a single-cycle load to the serializer, and tracks the serializer's busy_i until the word has been shifted out. Requests whose bit-count is below 3 are rejected and counted; they never reach the serializer.

Parameters:
N, 4, number of requesters (2..8)
CNT_W, 8, width of the rejected-request counter

Ports:
clk_i  in  1  clock
arstn_i  in  1  asynchronous active-low reset
req_data_i  in  16*N  requester words; slice k = [16k+15:16k]
req_mod_i  in  4*N  requester bit counts; slice k = [4k+3:4k]
req_val_i  in  N  request valid per requester
req_ready_o  out  N  request accepted (one-hot, combinational)
ser_data_o  out  16  word to serializer
ser_data_mod_o  out  4  bit count to serializer
ser_data_val_o  out  1  single-cycle load strobe to serializer
ser_busy_i  in  1  serializer busy
grant_id_o  out  $clog2(N)  index of the current or last owner
active_o  out  1  transaction in flight (state != IDLE)
done_o  out  1  one-cycle pulse when the serializer drops busy
drop_cnt_o  out  CNT_W  count of rejected requests (mod < 3), saturating
err_o  out  1  sticky: serializer failed to assert busy after a load

Behaviour:
- Reset (arstn_i low, asynchronous) clears all registered outputs:
  - ser_data_o=0, ser_data_mod_o=0, ser_data_val_o=0, done_o=0, drop_cnt_o=0, err_o=0, grant_id_o=0.
  - FSM goes to IDLE; round-robin pointer = 0.
- Reset mid-transaction drops the word; no done_o is generated.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Arbitration is combinational over req_val_i. Priority starts at (ptr+1) mod N and wraps; ptr is the last granted index.
  - req_ready_o[w]=1 only for winner w, only in IDLE, only if ser_busy_i=0. Transfer occurs on the edge where req_val_i[w] && req_ready_o[w].
  - On transfer: ptr<=w; grant_id_o<=w; ser_data_o/ser_data_mod_o <= slice w.
  - If mod >= 3: go to ISSUE.
  - If mod < 3: stay IDLE; drop_cnt_o <= drop_cnt_o+1, saturating at all-ones; no strobe. The next grant may occur on the following cycle.
- ISSUE: ser_data_val_o=1 for exactly this cycle; data/mod held stable; go to WAIT_BUSY.
- WAIT_BUSY (one cycle):
  - ser_busy_i=1: go to WAIT_DONE.
  - ser_busy_i=0: set err_o, go to IDLE, no done_o.
- WAIT_DONE: remain while ser_busy_i=1. On ser_busy_i=0, pulse done_o for 1 cycle (registered, asserted in the cycle after busy is seen low) and go to IDLE.
- ser_data_o/ser_data_mod_o hold their last value outside ISSUE.
- req_ready_o is 0 in all non-IDLE states. Requesters keep val and data stable until ready.
- Minimum spacing between strobes for a word of M bits (serializer busy for M cycles): IDLE + ISSUE + WAIT_BUSY + (M-1) WAIT_DONE cycles + return to IDLE.
- N=1: pointer logic degenerates and the single requester is always the winner.
- err_o clears only on reset.

Test Plan:
- Single request k=2, data=16'hA5C3, mod=8 -> req_ready_o=4'b0100 for 1 cycle; next cycle ser_data_val_o=1 with ser_data_o=16'hA5C3, ser_data_mod_o=8; busy 8 cycles; done_o one pulse; grant_id_o=2.
- All four requesters valid continuously, mod=4 -> grants in order 1,2,3,0,1 (ptr starts 0); exactly one strobe per transaction; no strobe while busy.
- Requester 0 with mod=2, then mod=0 -> two ready pulses, no ser_data_val_o, drop_cnt_o=2; requester 1 (mod=15) granted the cycle after.
- Serializer model stubbed to never assert busy -> err_o=1 after WAIT_BUSY; FSM back in IDLE; next request still served; err_o stays 1.
- arstn_i pulsed low while in WAIT_DONE with mod=12 -> all outputs 0 immediately, no done_o; after release, ptr=0, so requester 1 is granted first.
- Drop saturation with CNT_W=2 -> five rejected requests give drop_cnt_o=3.
